// File: rtl/sobel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sobel_pkg                                                     |
// | Desc     : Shared types and constants for the streaming Sobel filter:    |
// |            FSM state encoding, 3x3 kernels and magnitude-mode codes.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package sobel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } sobel_state_t;

    // Row 0 is the upper line, column 0 the leftmost pixel.
    localparam logic signed [2:0] SOBEL_GX [3][3] = '{
        '{-3'sd1, 3'sd0, 3'sd1},
        '{-3'sd2, 3'sd0, 3'sd2},
        '{-3'sd1, 3'sd0, 3'sd1}
    };

    localparam logic signed [2:0] SOBEL_GY [3][3] = '{
        '{-3'sd1, -3'sd2, -3'sd1},
        '{ 3'sd0,  3'sd0,  3'sd0},
        '{ 3'sd1,  3'sd2,  3'sd1}
    };

    localparam logic MAG_SUM = 1'b0;
    localparam logic MAG_MAX = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sobel_line_buffer                                             |
// | Desc     : One image line of storage. On each shift the incoming pixel   |
// |            is stored at the current column and the next column's pixel   |
// |            from the previous line is fetched into a registered output,   |
// |            so dout always holds the line-above pixel for the column that |
// |            is about to arrive.                                           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     shift_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_dout;

    // Store the current column and prefetch the next one in the same shift.
    always_ff @(posedge clock) begin
        if (shift_en) begin
            r_dout         <= r_mem[rd_addr];
            r_mem[wr_addr] <= din;
        end
    end

    assign dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/sobel_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sobel_stream                                                  |
// | Desc     : Streaming 3x3 Sobel edge-magnitude filter between an input    |
// |            and an output pixel FIFO. Two chained line buffers feed a     |
// |            3x3 window; the right-hand window column is the live input    |
// |            pixel plus the two line-buffer outputs, so the output lags    |
// |            the input by exactly one line plus one pixel.                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int PIXEL_W    = 8,
    parameter int MAX_WIDTH  = 1024,
    parameter int MAX_HEIGHT = 1024,
    parameter int GRAD_SHIFT = 1
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]  cfg_width,
    input  logic [$clog2(MAX_HEIGHT+1)-1:0] cfg_height,
    input  logic                            cfg_mode,
    input  logic                            cfg_thr_en,
    input  logic [PIXEL_W-1:0]              cfg_thr,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            cfg_err,
    output logic                            in_rd_en,
    input  logic                            in_empty,
    input  logic [PIXEL_W-1:0]              in_dout,
    output logic                            out_wr_en,
    input  logic                            out_full,
    output logic [PIXEL_W-1:0]              out_din
);

    localparam int c_xw = $clog2(MAX_WIDTH+1);
    localparam int c_yw = $clog2(MAX_HEIGHT+1);
    localparam int c_aw = $clog2(MAX_WIDTH);
    localparam int c_gw = PIXEL_W + 4;
    localparam logic [c_gw:0] c_sat = {5'b00000, {PIXEL_W{1'b1}}};

    sobel_state_t r_state, w_next_state;

    logic [c_xw-1:0]    r_width, r_rx, r_ox, w_rx_next;
    logic [c_yw-1:0]    r_height, r_ry, r_oy;
    logic               r_mode, r_thr_en;
    logic [PIXEL_W-1:0] r_thr;
    logic               r_done, r_cfg_err;

    logic w_rd, w_wr, w_size_ok;
    logic w_rx_end, w_ry_end, w_ox_end, w_oy_end, w_border;

    logic [PIXEL_W-1:0] w_lb1_dout, w_lb2_dout;
    logic [PIXEL_W-1:0] r_win [3][2];
    logic [PIXEL_W-1:0] w_pix [3][3];

    logic signed [c_gw-1:0] w_gx, w_gy;
    logic [c_gw-1:0]        w_ax, w_ay;
    logic [c_gw:0]          w_sum, w_mag;
    logic [PIXEL_W-1:0]     w_sat, w_val;

    assign w_size_ok = (cfg_width  >= c_xw'(3)) && (cfg_width  <= c_xw'(MAX_WIDTH)) &&
                       (cfg_height >= c_yw'(3)) && (cfg_height <= c_yw'(MAX_HEIGHT));

    assign w_rx_end  = (r_rx == r_width  - c_xw'(1));
    assign w_ry_end  = (r_ry == r_height - c_yw'(1));
    assign w_ox_end  = (r_ox == r_width  - c_xw'(1));
    assign w_oy_end  = (r_oy == r_height - c_yw'(1));
    assign w_rx_next = w_rx_end ? '0 : r_rx + c_xw'(1);
    assign w_border  = (r_ox == '0) || w_ox_end || (r_oy == '0) || w_oy_end;

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // Next state and the combinational FIFO handshakes.
    always_comb begin
        w_next_state = r_state;
        w_rd         = 1'b0;
        w_wr         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && w_size_ok) w_next_state = PRIME;
            end
            PRIME: begin
                w_rd = !in_empty;
                // Pixel index W sits at (0,1): the window is primed after it.
                if (w_rd && (r_rx == '0) && (r_ry == c_yw'(1))) w_next_state = RUN;
            end
            RUN: begin
                w_rd = !in_empty && !out_full;
                w_wr = w_rd;
                if (w_rd && w_rx_end && w_ry_end) w_next_state = DRAIN;
            end
            DRAIN: begin
                w_wr = !out_full;
                if (w_wr && w_ox_end && w_oy_end) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Configuration latch, read/write position counters and status pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_width   <= '0;
            r_height  <= '0;
            r_mode    <= 1'b0;
            r_thr_en  <= 1'b0;
            r_thr     <= '0;
            r_rx      <= '0;
            r_ry      <= '0;
            r_ox      <= '0;
            r_oy      <= '0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if ((r_state == IDLE) && start) begin
                if (w_size_ok) begin
                    r_width  <= cfg_width;
                    r_height <= cfg_height;
                    r_mode   <= cfg_mode;
                    r_thr_en <= cfg_thr_en;
                    r_thr    <= cfg_thr;
                    r_rx     <= '0;
                    r_ry     <= '0;
                    r_ox     <= '0;
                    r_oy     <= '0;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end
            if (w_rd) begin
                r_rx <= w_rx_next;
                if (w_rx_end) r_ry <= w_ry_end ? '0 : r_ry + c_yw'(1);
            end
            if (w_wr) begin
                r_ox <= w_ox_end ? '0 : r_ox + c_xw'(1);
                if (w_ox_end) r_oy <= w_oy_end ? '0 : r_oy + c_yw'(1);
                if ((r_state == DRAIN) && w_ox_end && w_oy_end) r_done <= 1'b1;
            end
        end
    end

    sobel_line_buffer #(
        .DEPTH (MAX_WIDTH),
        .WIDTH (PIXEL_W)
    ) u_line1 (
        .clock    (clock),
        .shift_en (w_rd),
        .wr_addr  (r_rx[c_aw-1:0]),
        .rd_addr  (w_rx_next[c_aw-1:0]),
        .din      (in_dout),
        .dout     (w_lb1_dout)
    );

    sobel_line_buffer #(
        .DEPTH (MAX_WIDTH),
        .WIDTH (PIXEL_W)
    ) u_line2 (
        .clock    (clock),
        .shift_en (w_rd),
        .wr_addr  (r_rx[c_aw-1:0]),
        .rd_addr  (w_rx_next[c_aw-1:0]),
        .din      (w_lb1_dout),
        .dout     (w_lb2_dout)
    );

    // Assemble the 3x3 window: two registered columns plus the live right column.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_pix[r][0] = r_win[r][0];
            w_pix[r][1] = r_win[r][1];
        end
        w_pix[0][2] = w_lb2_dout;
        w_pix[1][2] = w_lb1_dout;
        w_pix[2][2] = in_dout;
    end

    // Slide the window one column left on every accepted input pixel.
    always_ff @(posedge clock) begin
        if (w_rd) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= w_pix[r][2];
            end
        end
    end

    // Kernel convolution, magnitude, saturation and optional threshold.
    always_comb begin
        w_gx = '0;
        w_gy = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_gx = w_gx + c_gw'(SOBEL_GX[r][c]) * $signed({4'b0000, w_pix[r][c]});
                w_gy = w_gy + c_gw'(SOBEL_GY[r][c]) * $signed({4'b0000, w_pix[r][c]});
            end
        end
        w_ax  = w_gx[c_gw-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
        w_ay  = w_gy[c_gw-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
        w_sum = {1'b0, w_ax} + {1'b0, w_ay};
        if (r_mode == MAG_MAX) w_mag = (w_ax > w_ay) ? {1'b0, w_ax} : {1'b0, w_ay};
        else                   w_mag = w_sum >> GRAD_SHIFT;
        w_sat = (w_mag > c_sat) ? '1 : w_mag[PIXEL_W-1:0];
        w_val = r_thr_en ? ((w_sat >= r_thr) ? '1 : '0) : w_sat;
    end

    // Frame borders are forced to zero; drain-phase outputs are all border pixels.
    assign out_din   = ((r_state == RUN) && !w_border) ? w_val : '0;
    assign in_rd_en  = w_rd;
    assign out_wr_en = w_wr;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sobel_stream                                               |
// | Desc     : Scoreboard bench for sobel_stream: FIFO models on both sides, |
// |            expected pixels queued per frame, monitor pops and compares.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sobel_stream;

    logic       clock;
    logic       reset_n;
    logic [5:0] cfg_width, cfg_height;
    logic       cfg_mode, cfg_thr_en;
    logic [7:0] cfg_thr;
    logic       start, busy, done, cfg_err;
    logic       in_rd_en, in_empty, out_wr_en, out_full;
    logic [7:0] in_dout, out_din;

    int tests = 0, fails = 0;
    int reads = 0, writes = 0, done_cnt = 0, err_cnt = 0;
    bit rd_pop = 1'b0, rand_en = 1'b0;
    int in_q[$];
    int exp_q[$];
    int frm[256];

    sobel_stream #(
        .PIXEL_W    (8),
        .MAX_WIDTH  (32),
        .MAX_HEIGHT (32),
        .GRAD_SHIFT (1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_mode   (cfg_mode),
        .cfg_thr_en (cfg_thr_en),
        .cfg_thr    (cfg_thr),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .in_rd_en   (in_rd_en),
        .in_empty   (in_empty),
        .in_dout    (in_dout),
        .out_wr_en  (out_wr_en),
        .out_full   (out_full),
        .out_din    (out_din)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int px(input int x, input int y, input int w);
        return frm[y*w + x];
    endfunction

    // Reference Sobel computed from neighbour coordinates in plain integers.
    function automatic int model(input int x, input int y, input int w,
                                 input int mode, input int thr_en, input int thr);
        int gx, gy, m;
        gx = px(x+1,y-1,w) + 2*px(x+1,y,w) + px(x+1,y+1,w)
           - px(x-1,y-1,w) - 2*px(x-1,y,w) - px(x-1,y+1,w);
        gy = px(x-1,y+1,w) + 2*px(x,y+1,w) + px(x+1,y+1,w)
           - px(x-1,y-1,w) - 2*px(x,y-1,w) - px(x+1,y-1,w);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = (mode != 0) ? ((gx > gy) ? gx : gy) : ((gx + gy) / 2);
        if (m > 255) m = 255;
        if (thr_en != 0) m = (m >= thr) ? 255 : 0;
        return m;
    endfunction

    function automatic int pixel(input int kind, input int x);
        case (kind)
            1:       return (x < 3) ? 10 : 20;
            2:       return (x < 4) ? 0 : 255;
            3:       return int'($urandom_range(0, 255));
            default: return 100;
        endcase
    endfunction

    function automatic int expect_pix(input int kind, input int x, input int y, input int w,
                                      input int h, input int mode, input int thr_en, input int thr);
        int v;
        if (x == 0 || x == w-1 || y == 0 || y == h-1) return 0;
        case (kind)
            1: begin
                if (x != 2 && x != 3) return 0;
                v = (mode != 0) ? 40 : 20;
                if (thr_en != 0) v = (v >= thr) ? 255 : 0;
                return v;
            end
            2:       return (x == 3 || x == 4) ? 255 : 0;
            3:       return model(x, y, w, mode, thr_en, thr);
            default: return 0;
        endcase
    endfunction

    // Output-side monitor: handshake legality and scoreboard comparison.
    initial forever begin
        @(negedge clock);
        if (in_rd_en) begin
            check("rd_while_empty", int'(in_empty), 0);
            reads++;
            rd_pop = 1'b1;
        end
        if (out_wr_en) begin
            check("wr_while_full", int'(out_full), 0);
            writes++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got pixel %0d, expected no write", out_din);
            end else begin
                check($sformatf("pix%0d", writes-1), int'(out_din), exp_q.pop_front());
            end
        end
        if (done)    done_cnt++;
        if (cfg_err) err_cnt++;
    end

    // FIFO models: first-word-fall-through input, optional random stalls.
    initial forever begin
        @(posedge clock);
        #1;
        if (rd_pop) begin
            if (in_q.size() > 0) void'(in_q.pop_front());
            rd_pop = 1'b0;
        end
        in_empty = (in_q.size() == 0) || (rand_en && ($urandom_range(0, 1) == 1));
        in_dout  = (in_q.size() > 0) ? 8'(in_q[0]) : 8'd0;
        out_full = rand_en && ($urandom_range(0, 1) == 1);
    end

    task automatic load_frame(input int w, input int h, input int mode,
                              input int thr_en, input int thr, input int kind);
        reads = 0; writes = 0; done_cnt = 0;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                frm[y*w + x] = pixel(kind, x);
                in_q.push_back(frm[y*w + x]);
            end
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                exp_q.push_back(expect_pix(kind, x, y, w, h, mode, thr_en, thr));
        @(posedge clock); #1;
        cfg_width  = 6'(w);
        cfg_height = 6'(h);
        cfg_mode   = 1'(mode);
        cfg_thr_en = 1'(thr_en);
        cfg_thr    = 8'(thr);
        start      = 1'b1;
        @(posedge clock); #1;
        start      = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input int mode,
                             input int thr_en, input int thr, input int kind, input string tag);
        int cyc;
        load_frame(w, h, mode, thr_en, thr, kind);
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        if (done_cnt == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", tag, cyc);
        end
        #1;
        check({tag, "_busy_after"}, int'(busy), 0);
        repeat (3) @(negedge clock);
        check({tag, "_reads"},  reads,  w*h);
        check({tag, "_writes"}, writes, w*h);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_leftover"}, exp_q.size(), 0);
        exp_q.delete();
        in_q.delete();
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0; start = 1'b0;
        cfg_width = '0; cfg_height = '0; cfg_mode = 1'b0; cfg_thr_en = 1'b0; cfg_thr = '0;
        in_empty = 1'b1; out_full = 1'b0; in_dout = '0;
        repeat (3) @(negedge clock);
        check("rst_busy",    int'(busy),      0);
        check("rst_done",    int'(done),      0);
        check("rst_cfg_err", int'(cfg_err),   0);
        check("rst_rd_en",   int'(in_rd_en),  0);
        check("rst_wr_en",   int'(out_wr_en), 0);
        check("rst_dout",    int'(out_din),   0);
        @(posedge clock); #2;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        run_frame(5, 4, 0, 0, 0, 0, "flat");
        run_frame(6, 4, 0, 0, 0, 1, "step_sum");
        run_frame(6, 4, 1, 0, 0, 1, "step_max");
        run_frame(6, 4, 0, 1, 21, 1, "thr21");
        run_frame(6, 4, 0, 1, 20, 1, "thr20");
        run_frame(8, 8, 0, 0, 0, 2, "sat");
        rand_en = 1'b1;
        run_frame(16, 9, 0, 0, 0, 3, "rand_sum");
        run_frame(16, 9, 1, 1, 90, 3, "rand_max_thr");
        rand_en = 1'b0;
        repeat (2) @(posedge clock);

        // Illegal width: error pulse, no FIFO traffic.
        reads = 0; writes = 0; err_cnt = 0;
        for (int i = 0; i < 5; i++) in_q.push_back(i + 1);
        @(posedge clock); #1;
        cfg_width = 6'd2; cfg_height = 6'd4; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("cfg_err_pulse",  err_cnt, 1);
        check("cfg_err_reads",  reads,   0);
        check("cfg_err_writes", writes,  0);
        check("cfg_err_busy",   int'(busy), 0);
        in_q.delete();

        // Reset in the middle of RUN.
        load_frame(16, 9, 0, 0, 0, 3);
        cyc = 0;
        while (writes < 5 && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        check("midrun_reached", int'(writes >= 5), 1);
        @(posedge clock); #3;
        check("pre_reset_wr_en", int'(out_wr_en), 1);
        reset_n = 1'b0;
        #1;
        check("reset_rd_en", int'(in_rd_en),  0);
        check("reset_wr_en", int'(out_wr_en), 0);
        check("reset_dout",  int'(out_din),   0);
        check("reset_busy",  int'(busy),      0);
        in_q.delete();
        exp_q.delete();
        rd_pop = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        run_frame(5, 4, 0, 0, 0, 0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
